// File: rtl/bayer_pkg.sv
// Shared Bayer definitions: transmitter FSM states and CFA tag codes,
// reused by the receiver side.
package bayer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LINE   = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } bayer_state_e;

    localparam logic [1:0] CFA_R  = 2'd0;
    localparam logic [1:0] CFA_GR = 2'd1;
    localparam logic [1:0] CFA_GB = 2'd2;
    localparam logic [1:0] CFA_B  = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bayer_cfa_tag.sv
// CFA colour of a pixel from the parity of its coordinates after the
// frame's pixel-shift offset is applied.
module bayer_cfa_tag
    import bayer_pkg::*;
(
    input  logic       x_lsb,
    input  logic       y_lsb,
    input  logic [1:0] shift,
    output logic [1:0] cfa
);

    logic [1:0] parity;

    assign parity = {y_lsb ^ shift[1], x_lsb ^ shift[0]};

    always_comb begin
        cfa = CFA_R;
        case (parity)
            2'b00:   cfa = CFA_R;
            2'b01:   cfa = CFA_GR;
            2'b10:   cfa = CFA_GB;
            default: cfa = CFA_B;
        endcase
    end

endmodule

// File: rtl/bayer_pixel_tx.sv
// Raw Bayer frame transmitter: pulls IMG_W x IMG_H samples from a valid/ready
// source and emits them with frame/line valid, CFA tags and blanking.
module bayer_pixel_tx
    import bayer_pkg::*;
#(
    parameter int PIX_W  = 12,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int HBLANK = 16,
    parameter int VBLANK = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       shift,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_fv,
    output logic             out_lv,
    output logic [1:0]       out_cfa,
    output logic             busy,
    output logic             frame_done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int BW = $clog2(max_int(HBLANK, VBLANK) + 1);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [BW-1:0] H_LAST = BW'(HBLANK - 1);
    localparam logic [BW-1:0] V_LAST = BW'(VBLANK - 1);

    bayer_state_e   state, state_nxt;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [BW-1:0]  bcnt;
    logic [1:0]     shift_q;
    logic [1:0]     cfa;
    logic           xfer, x_last, y_last, h_end, v_end;

    assign xfer   = in_valid && (state == ST_LINE);
    assign x_last = (x == X_LAST);
    assign y_last = (y == Y_LAST);
    assign h_end  = (bcnt == H_LAST);
    assign v_end  = (bcnt == V_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_LINE;
            ST_LINE:   if (xfer && x_last) state_nxt = y_last ? ST_VBLANK : ST_HBLANK;
            ST_HBLANK: if (h_end) state_nxt = ST_LINE;
            ST_VBLANK: if (v_end) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_LINE);
        busy     = (state != ST_IDLE);
    end

    // Blank counter restarts on every entry to a blanking state, so it
    // never needs to count past the longer of the two intervals.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x       <= '0;
            y       <= '0;
            bcnt    <= '0;
            shift_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x       <= '0;
                        y       <= '0;
                        bcnt    <= '0;
                        shift_q <= shift;
                    end
                end
                ST_LINE: begin
                    if (xfer) begin
                        if (x_last) begin
                            x    <= '0;
                            bcnt <= '0;
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end
                ST_HBLANK: begin
                    if (h_end) begin
                        bcnt <= '0;
                        y    <= y + YW'(1);
                    end else begin
                        bcnt <= bcnt + BW'(1);
                    end
                end
                ST_VBLANK: begin
                    if (v_end) bcnt <= '0;
                    else       bcnt <= bcnt + BW'(1);
                end
                default: ;
            endcase
        end
    end

    bayer_cfa_tag u_cfa_tag (
        .x_lsb (x[0]),
        .y_lsb (y[0]),
        .shift (shift_q),
        .cfa   (cfa)
    );

    // lv stays up through mid-line stalls (x != 0); fv additionally bridges
    // the horizontal blanking and any stall at the start of a later line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_cfa    <= 2'b00;
            out_lv     <= 1'b0;
            out_fv     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= xfer;
            if (xfer) begin
                out_data <= in_data;
                out_cfa  <= cfa;
            end
            out_lv     <= (state == ST_LINE) && (xfer || (x != '0));
            out_fv     <= ((state == ST_LINE) && (xfer || (x != '0) || (y != '0)))
                          || (state == ST_HBLANK);
            frame_done <= (state == ST_VBLANK) && v_end;
        end
    end

endmodule

// File: tb/tb_bayer_pixel_tx.sv
// Randomized frame-level bench for bayer_pixel_tx with a timeline model of
// each frame derived from pixel transfer times.
module tb_bayer_pixel_tx;

    localparam int PW = 12;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int HB = 2;
    localparam int VB = 3;
    localparam int N  = W * H;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    shift = 2'b00;
    logic [PW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] out_data;
    logic          out_valid;
    logic          out_fv;
    logic          out_lv;
    logic [1:0]    out_cfa;
    logic          busy;
    logic          frame_done;

    int checks = 0;
    int errors = 0;
    int cur_t  = 0;

    bayer_pixel_tx #(
        .PIX_W(PW), .IMG_W(W), .IMG_H(H), .HBLANK(HB), .VBLANK(VB)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .shift(shift),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_fv(out_fv),
        .out_lv(out_lv), .out_cfa(out_cfa), .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, cur_t, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"},  32'(in_ready),   32'd0);
        chk({tag, "_vld"},  32'(out_valid),  32'd0);
        chk({tag, "_data"}, 32'(out_data),   32'd0);
        chk({tag, "_cfa"},  32'(out_cfa),    32'd0);
        chk({tag, "_lv"},   32'(out_lv),     32'd0);
        chk({tag, "_fv"},   32'(out_fv),     32'd0);
        chk({tag, "_busy"}, 32'(busy),       32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
    endtask

    // Tag from coordinate parity after the shift, written as plain sums.
    function automatic logic [1:0] exp_cfa(input int k, input logic [1:0] sh);
        int xs, ys;
        xs = (k % W) + int'(sh[0]);
        ys = (k / W) + int'(sh[1]);
        return {(ys % 2) == 1, (xs % 2) == 1};
    endfunction

    // One frame. sl>0 holds in_valid low for sl LINE cycles right before
    // pixel sp; noise adds ignored start pulses, shift changes and in_valid
    // toggling outside LINE; abort_t>=0 pulses reset at that cycle.
    task automatic run_frame(input logic [1:0] sh, input int sp, input int sl,
                             input bit noise, input int abort_t);
        int T[N];
        int s[H];
        logic [PW-1:0] d[N];
        int idx, last, done_t, k;
        idx = 0;
        for (int L = 0; L < H; L++) begin
            s[L] = (L == 0) ? 0 : T[L*W-1] + 1 + HB;
            for (int c = 0; c < W; c++) begin
                k = L*W + c;
                T[k] = s[L] + c + ((sl > 0 && k >= sp && k/W == sp/W) ? sl : 0);
            end
        end
        for (int i = 0; i < N; i++) d[i] = PW'($urandom);
        last   = T[N-1];
        done_t = last + VB + 1;

        @(negedge clock);
        start = 1'b1; shift = sh; in_valid = 1'b1; in_data = d[0];
        for (int t = 0; t <= done_t + 2; t++) begin
            bit v_e, lv_e, rdy_e, fv_e, busy_e, done_e, stall;
            int ke;
            @(negedge clock);
            cur_t = t;
            v_e = 0; lv_e = 0; rdy_e = 0; ke = 0;
            for (int i = 0; i < N; i++)
                if (T[i] + 1 == t) begin v_e = 1; ke = i; end
            for (int L = 0; L < H; L++) begin
                if (t >= T[L*W] + 1 && t <= T[L*W+W-1] + 1) lv_e = 1;
                if (t >= s[L] && t <= T[L*W+W-1]) rdy_e = 1;
            end
            fv_e   = (t >= T[0] + 1) && (t <= last + 1);
            busy_e = (t <= last + VB);
            done_e = (t == done_t);
            chk("in_ready",   32'(in_ready),   32'(rdy_e));
            chk("out_valid",  32'(out_valid),  32'(v_e));
            chk("out_lv",     32'(out_lv),     32'(lv_e));
            chk("out_fv",     32'(out_fv),     32'(fv_e));
            chk("busy",       32'(busy),       32'(busy_e));
            chk("frame_done", 32'(frame_done), 32'(done_e));
            if (v_e) begin
                chk("out_data", 32'(out_data), 32'(d[ke]));
                chk("out_cfa",  32'(out_cfa),  32'(exp_cfa(ke, sh)));
            end
            if (t == abort_t) begin
                reset_n = 1'b0;
                #1;
                chk_zero("abort");
                repeat (2) begin
                    @(negedge clock);
                    chk_zero("abort_hold");
                end
                reset_n = 1'b1; start = 1'b0; in_valid = 1'b0;
                return;
            end
            start = noise && t >= 1 && t <= last + VB &&
                    ($urandom_range(3) == 0 || t == T[W-1] + 1);
            if (noise) shift = 2'($urandom);
            stall    = (sl > 0) && (t >= T[sp] - sl) && (t < T[sp]);
            in_valid = rdy_e ? !stall : (noise ? 1'($urandom_range(1)) : 1'b1);
            in_data  = (idx < N) ? d[idx] : PW'($urandom);
            if (in_valid && in_ready) idx++;
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout t=%0d", cur_t);
        $fatal(1, "timeout");
    end

    initial begin
        int L, c;
        reset_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = '1; shift = 2'b11;
        cur_t = -1;
        repeat (3) @(negedge clock);
        chk_zero("reset");
        reset_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_rdy",  32'(in_ready), 32'd0);

        run_frame(2'd0, 0, 0, 1'b0, -1);
        run_frame(2'd3, 0, 0, 1'b1, -1);
        run_frame(2'd0, 2, 3, 1'b0, -1);
        run_frame(2'd1, 0, 0, 1'b1, -1);
        run_frame(2'd0, 0, 0, 1'b0, W + HB + 1);
        run_frame(2'd2, 0, 0, 1'b0, -1);

        for (int f = 0; f < 20; f++) begin
            L = $urandom_range(H - 1);
            c = $urandom_range(W - 1, 1);
            run_frame(2'($urandom), L*W + c, $urandom_range(4), 1'($urandom_range(1)), -1);
            repeat ($urandom_range(3)) @(negedge clock);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
